// File: rtl/serial_bit_receiver_if.sv
// Handshake bundle between the serial receiver (slave) and its stimulus/consumer (master).
// Carries the serial line, the ready input and the registered word/flag outputs.
interface serial_bit_receiver_if #(
  parameter int DATA_BITS = 8
);
  logic                 d;
  logic                 ready;
  logic [DATA_BITS-1:0] data_out;
  logic                 valid;
  logic                 frame_err;
  logic                 overrun;

  modport slave (
    input  d,
    input  ready,
    output data_out,
    output valid,
    output frame_err,
    output overrun
  );

  modport master (
    output d,
    output ready,
    input  data_out,
    input  valid,
    input  frame_err,
    input  overrun
  );
endinterface

// File: rtl/serial_bit_receiver.sv
// One-bit-per-clock serial frame receiver: start, DATA_BITS data (LSB first), stop.
// Define SERIAL_RX_PARITY_EN to expect one even-parity bit between data and stop.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  S_IDLE   | line idle, waiting for a 0 (start bit)
//  S_DATA   | sampling data bit cnt_q into shift_q
//  S_PARITY | sampling the parity bit (parity build only)
//  S_STOP   | sampling the stop bit and evaluating the whole frame
module serial_bit_receiver #(
  parameter int DATA_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_bit_receiver_if.slave  rx
);

  localparam int CW = $clog2(DATA_BITS) + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
`ifdef SERIAL_RX_PARITY_EN
  localparam logic [1:0] S_PARITY = 2'd2;
`endif
  localparam logic [1:0] S_STOP   = 2'd3;

  if (DATA_BITS < 1 || DATA_BITS > 16) begin : g_bad_width
    $error("serial_bit_receiver: DATA_BITS must be in 1..16");
  end

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 par_ok;
  logic                 frame_ok;

`ifdef SERIAL_RX_PARITY_EN
  logic                 par_q, par_d;

  // Even parity: data bits together with the parity bit must XOR to 0.
  assign par_ok = ~(^shift_q ^ par_q);
`else
  assign par_ok = 1'b1;
`endif

  assign frame_ok = rx.d & par_ok;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q & ~rx.ready;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (!rx.d) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
      end

      S_DATA: begin
        for (int i = 0; i < DATA_BITS; i++) begin
          if (cnt_q == CW'(i)) shift_d[i] = rx.d;
        end
        if (cnt_q == CW'(DATA_BITS - 1)) begin
          cnt_d   = '0;
`ifdef SERIAL_RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

`ifdef SERIAL_RX_PARITY_EN
      S_PARITY: begin
        par_d   = rx.d;
        state_d = S_STOP;
      end
`endif

      S_STOP: begin
        // The stop sample is always consumed here, so a 0 stop bit never restarts a frame.
        state_d = S_IDLE;
        if (frame_ok) begin
          if (!valid_q || rx.ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end else begin
          ferr_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef SERIAL_RX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign rx.data_out  = data_q;
  assign rx.valid     = valid_q;
  assign rx.frame_err = ferr_q;
  assign rx.overrun   = ovr_q;

endmodule

// File: tb/tb_serial_bit_receiver.sv
// Bench for serial_bit_receiver: table of frames with expected outcomes, a scoreboard of
// expected output events (kind, edge, data), and hand-written reset/handshake sequences.
module tb_serial_bit_receiver;

  localparam int DB     = 8;
  localparam int K_NONE = -1;
  localparam int K_WORD = 0;
  localparam int K_FERR = 1;
  localparam int K_OVR  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  serial_bit_receiver_if #(.DATA_BITS(DB)) bus ();

  serial_bit_receiver #(.DATA_BITS(DB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          kind;
    logic [DB-1:0] data;
  } exp_t;

  typedef struct {
    logic [DB-1:0] data;
    bit            par_bad;
    bit            stop;
    bit            rdy;
    int            idle;
    int            kind;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[$];

  int n_cmp    = 0;
  int n_err    = 0;
  int edge_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Output monitor: every frame_err/overrun pulse and every word load must match the queue head.
  logic          v_prev = 1'b0;
  logic          r_prev = 1'b0;
  logic [DB-1:0] d_prev = '0;

  always @(negedge clk) begin
    int   kind;
    exp_t e;
    kind = K_NONE;
    if (rst_n) begin
      while (sbq.size() > 0 && sbq[0].cyc < edge_cnt) begin
        n_cmp++;
        n_err++;
        $display("FAIL missing_event: got nothing, expected kind %0d at edge %0d", sbq[0].kind, sbq[0].cyc);
        void'(sbq.pop_front());
      end
      if (bus.frame_err)                       kind = K_FERR;
      else if (bus.overrun)                    kind = K_OVR;
      else if (bus.valid && (!v_prev || r_prev)) kind = K_WORD;

      if (kind != K_NONE) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_event: got kind %0d at edge %0d, expected none", kind, edge_cnt);
        end else begin
          e = sbq.pop_front();
          check("event_kind", kind, e.kind);
          check("event_edge", edge_cnt, e.cyc);
          if (e.kind == K_WORD) check("event_data", 32'(bus.data_out), 32'(e.data));
        end
      end else if (v_prev && r_prev) begin
        check("valid_clear", 32'(bus.valid), 32'd0);
      end
      if (v_prev && !r_prev) begin
        check("valid_hold", 32'(bus.valid), 32'd1);
        check("data_hold", 32'(bus.data_out), 32'(d_prev));
      end
    end
    v_prev = bus.valid;
    r_prev = bus.ready;
    d_prev = bus.data_out;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.d = b;
    tick();
  endtask

  task automatic send_frame(input logic [DB-1:0] data, input bit par_bad, input bit stop,
                            input int kind);
    exp_t e;
    int   n;
    n = edge_cnt + 1;
`ifdef SERIAL_RX_PARITY_EN
    e.cyc = n + DB + 2;
`else
    e.cyc = n + DB + 1;
`endif
    e.kind = kind;
    e.data = data;
    if (kind != K_NONE) sbq.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(data[i]);
`ifdef SERIAL_RX_PARITY_EN
    send_bit((^data) ^ par_bad);
`endif
    send_bit(stop);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data_out"},  32'(bus.data_out),  32'd0);
    check({tag, "_valid"},     32'(bus.valid),     32'd0);
    check({tag, "_frame_err"}, 32'(bus.frame_err), 32'd0);
    check({tag, "_overrun"},   32'(bus.overrun),   32'd0);
  endtask

  initial begin
    logic [DB-1:0] last_good;
    logic [DB-1:0] abort_word;
    vec_t          v;

    bus.d     = 1'b1;
    bus.ready = 1'b0;
    rst_n     = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (3) tick();

    // Single good frame with ready held high: one-cycle valid, then cleared.
    bus.ready = 1'b1;
    send_frame(8'h5A, 1'b0, 1'b1, K_WORD);
    bus.d = 1'b1;
    repeat (2) tick();
    check("t1_valid_cleared", 32'(bus.valid), 32'd0);
    check("t1_data_kept", 32'(bus.data_out), 32'h5A);
    last_good = 8'h5A;

    vecs.push_back('{data: 8'hA5, par_bad: 1'b0, stop: 1'b1, rdy: 1'b1, idle: 0, kind: K_WORD});
    vecs.push_back('{data: 8'h3C, par_bad: 1'b0, stop: 1'b1, rdy: 1'b1, idle: 2, kind: K_WORD});
    vecs.push_back('{data: 8'h81, par_bad: 1'b0, stop: 1'b0, rdy: 1'b1, idle: 0, kind: K_FERR});
    vecs.push_back('{data: 8'h01, par_bad: 1'b0, stop: 1'b1, rdy: 1'b1, idle: 2, kind: K_WORD});
`ifdef SERIAL_RX_PARITY_EN
    vecs.push_back('{data: 8'h07, par_bad: 1'b1, stop: 1'b1, rdy: 1'b1, idle: 2, kind: K_FERR});
    vecs.push_back('{data: 8'h07, par_bad: 1'b0, stop: 1'b0, rdy: 1'b1, idle: 2, kind: K_FERR});
    vecs.push_back('{data: 8'h07, par_bad: 1'b0, stop: 1'b1, rdy: 1'b1, idle: 2, kind: K_WORD});
`endif
    vecs.push_back('{data: 8'h11, par_bad: 1'b0, stop: 1'b1, rdy: 1'b0, idle: 0, kind: K_WORD});
    vecs.push_back('{data: 8'h22, par_bad: 1'b0, stop: 1'b1, rdy: 1'b0, idle: 2, kind: K_OVR});

    for (int k = 0; k < vecs.size(); k++) begin
      v = vecs[k];
      bus.ready = v.rdy;
      send_frame(v.data, v.par_bad, v.stop, v.kind);
      bus.d = 1'b1;
      repeat (v.idle) tick();
      if (v.kind == K_WORD) last_good = v.data;
      if (v.kind == K_FERR) check("ferr_data_unchanged", 32'(bus.data_out), 32'(last_good));
    end

    // Overrun left the first word pending; releasing ready must retire it.
    check("ovr_valid_pending", 32'(bus.valid), 32'd1);
    check("ovr_data_kept", 32'(bus.data_out), 32'h11);
    bus.ready = 1'b1;
    tick();
    check("ovr_valid_cleared", 32'(bus.valid), 32'd0);
    repeat (2) tick();

    // Mid-frame asynchronous reset after data bit 4, then a clean frame.
    abort_word = 8'h00;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(abort_word[i]);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    bus.d = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    send_frame(8'h3C, 1'b0, 1'b1, K_WORD);
    bus.d = 1'b1;
    repeat (3) tick();
    check("post_reset_data", 32'(bus.data_out), 32'h3C);

    repeat (4) tick();
    check("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
